// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified memory between the host load/inspect port and
// the CPU core. At most one access is granted per cycle. The core may lock the
// port for multi-word transfers; the lock is bounded so a waiting host is served
// after MAX_LOCK consecutive locked core grants. Reads return through a 2-cycle
// pipeline into per-requester hold registers with a one-cycle valid pulse.
module mem_port_arbiter #(
    parameter int AW       = 7,
    parameter int DW       = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic          Iclk,
    input  logic          Ireset,
    // host port
    input  logic          h_req,
    input  logic          h_wrb,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    // core port
    input  logic          c_req,
    input  logic          c_we,
    input  logic          c_lock,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    // memory port
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    // status
    output logic          lock_act
);

    localparam int            CW           = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_MAX     = CW'(MAX_LOCK);
    localparam logic [0:0]    ST_IDLE      = 1'b0;
    localparam logic [0:0]    ST_CORE_LOCK = 1'b1;
    localparam logic          WIN_HOST     = 1'b0;
    localparam logic          WIN_CORE     = 1'b1;

    logic [0:0]    state_q,    state_d;
    logic          last_win_q, last_win_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          h_rd_q,     h_rd_d;
    logic          c_rd_q,     c_rd_d;
    logic          h_rvalid_q, h_rvalid_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic [DW-1:0] h_rdata_q,  h_rdata_d;
    logic [DW-1:0] c_rdata_q,  c_rdata_d;

    logic          host_win;
    logic          core_win;
    logic [CW-1:0] cnt_next;

    // Winner selection: an unexpired core lock first, otherwise round-robin on ties.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        host_win = 1'b0;
        core_win = 1'b0;
        if (!Ireset) begin
            if (state_q == ST_CORE_LOCK && c_req && (!h_req || lock_cnt_q < LOCK_MAX)) begin
                core_win = 1'b1;
            end else if (h_req && c_req) begin
                if (last_win_q == WIN_CORE) host_win = 1'b1;
                else                        core_win = 1'b1;
            end else if (h_req) begin
                host_win = 1'b1;
            end else if (c_req) begin
                core_win = 1'b1;
            end
        end
    end

    // Memory drive: steer the winner's request onto the memory port.
    always_comb begin
        h_gnt   = host_win;
        c_gnt   = core_win;
        m_en    = host_win | core_win;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (host_win) begin
            m_we    = ~h_wrb;
            m_addr  = h_addr;
            m_wdata = h_wdata;
        end else if (core_win) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end
    end

    // Arbitration state: last winner, lock FSM and bounded lock counter.
    always_comb begin
        last_win_d = last_win_q;
        if (host_win) last_win_d = WIN_HOST;
        if (core_win) last_win_d = WIN_CORE;

        cnt_next = lock_cnt_q;
        if (core_win && c_lock && h_req && lock_cnt_q != LOCK_MAX) begin
            cnt_next = lock_cnt_q + CW'(1);
        end

        // Hitting the bound while the host waits forces the port back to IDLE.
        state_d = ST_IDLE;
        if (core_win && c_lock && !(h_req && cnt_next == LOCK_MAX)) begin
            state_d = ST_CORE_LOCK;
        end

        lock_cnt_d = (state_d == ST_IDLE) ? '0 : cnt_next;
    end

    // Read return pipeline: tag in N, capture memory data at end of N+1, pulse in N+2.
    always_comb begin
        h_rd_d     = host_win & h_wrb;
        c_rd_d     = core_win & ~c_we;
        h_rvalid_d = h_rd_q;
        c_rvalid_d = c_rd_q;
        h_rdata_d  = h_rd_q ? m_rdata : h_rdata_q;
        c_rdata_d  = c_rd_q ? m_rdata : c_rdata_q;
    end

    // State registers; reset clears in-flight reads and hold registers.
    always_ff @(posedge Iclk or posedge Ireset) begin
        if (Ireset) begin
            state_q    <= ST_IDLE;
            last_win_q <= WIN_CORE;
            lock_cnt_q <= '0;
            h_rd_q     <= 1'b0;
            c_rd_q     <= 1'b0;
            h_rvalid_q <= 1'b0;
            c_rvalid_q <= 1'b0;
            h_rdata_q  <= '0;
            c_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            last_win_q <= last_win_d;
            lock_cnt_q <= lock_cnt_d;
            h_rd_q     <= h_rd_d;
            c_rd_q     <= c_rd_d;
            h_rvalid_q <= h_rvalid_d;
            c_rvalid_q <= c_rvalid_d;
            h_rdata_q  <= h_rdata_d;
            c_rdata_q  <= c_rdata_d;
        end
    end

    assign h_rvalid = h_rvalid_q;
    assign c_rvalid = c_rvalid_q;
    assign h_rdata  = h_rdata_q;
    assign c_rdata  = c_rdata_q;
    assign lock_act = (state_q == ST_CORE_LOCK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed stimulus for mem_port_arbiter. Grants are compared in the cycle they
// are issued; expected read data is queued with its due cycle and a separate
// monitor compares it when the DUT raises an rvalid pulse.
module tb_mem_port_arbiter;

    logic        Iclk = 1'b0;
    logic        Ireset = 1'b1;
    logic        h_req = 1'b0, h_wrb = 1'b1;
    logic [6:0]  h_addr = '0;
    logic [15:0] h_wdata = '0;
    logic        h_gnt, h_rvalid;
    logic [15:0] h_rdata;
    logic        c_req = 1'b0, c_we = 1'b0, c_lock = 1'b0;
    logic [6:0]  c_addr = '0;
    logic [15:0] c_wdata = '0;
    logic        c_gnt, c_rvalid;
    logic [15:0] c_rdata;
    logic        m_en, m_we;
    logic [6:0]  m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic        lock_act;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t h_q[$];
    exp_t c_q[$];

    logic [15:0] mem [128];

    mem_port_arbiter #(.AW(7), .DW(16), .MAX_LOCK(4)) dut (
        .Iclk(Iclk), .Ireset(Ireset),
        .h_req(h_req), .h_wrb(h_wrb), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .lock_act(lock_act)
    );

    always #5 Iclk = ~Iclk;

    always @(posedge Iclk) cyc <= cyc + 1;

    // Memory contents start as 0xA000 | address so reads are easy to predict by hand.
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i);
    end

    // Synchronous single-port memory: read data valid the cycle after m_en.
    always @(posedge Iclk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata     <= mem[m_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-return monitor: every rvalid must match the head of its queue, on time.
    always @(negedge Iclk) begin : monitor
        exp_t e;
        if (h_rvalid) begin
            if (h_q.size() == 0) begin
                check("h_rvalid_spurious", h_rvalid, 1'b0);
            end else begin
                e = h_q.pop_front();
                check("h_rdata", h_rdata, e.data);
                check("h_rvalid_cycle", cyc, e.due);
            end
        end else if (h_q.size() != 0 && h_q[0].due <= cyc) begin
            e = h_q.pop_front();
            check("h_rvalid_missing", h_rvalid, 1'b1);
        end
        if (c_rvalid) begin
            if (c_q.size() == 0) begin
                check("c_rvalid_spurious", c_rvalid, 1'b0);
            end else begin
                e = c_q.pop_front();
                check("c_rdata", c_rdata, e.data);
                check("c_rvalid_cycle", cyc, e.due);
            end
        end else if (c_q.size() != 0 && c_q[0].due <= cyc) begin
            e = c_q.pop_front();
            check("c_rvalid_missing", c_rvalid, 1'b1);
        end
    end

    // One arbitration cycle: compare grants/memory drive, queue any expected read data.
    task automatic step(input logic eh, input logic ec, input logic [6:0] ea,
                        input logic ewe, input logic [15:0] erd, input logic elk);
        exp_t e;
        @(negedge Iclk);
        check("h_gnt", h_gnt, eh);
        check("c_gnt", c_gnt, ec);
        check("m_en", m_en, eh | ec);
        check("lock_act", lock_act, elk);
        if (eh | ec) begin
            check("m_addr", m_addr, ea);
            check("m_we", m_we, ewe);
            if (ewe) begin
                check("m_wdata", m_wdata, eh ? h_wdata : c_wdata);
            end else begin
                e.data = erd;
                e.due  = cyc + 2;
                if (eh) h_q.push_back(e);
                else    c_q.push_back(e);
            end
        end
        @(posedge Iclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic reset_pulse();
        Ireset = 1'b1;
        h_q.delete();
        c_q.delete();
        @(posedge Iclk);
        #1;
        Ireset = 1'b0;
    endtask

    initial begin
        // 1. Reset with random inputs: every output held at zero.
        for (int i = 0; i < 3; i++) begin
            h_req = 1'($urandom); h_wrb = 1'($urandom); h_addr = 7'($urandom);
            h_wdata = 16'($urandom); c_req = 1'($urandom); c_we = 1'($urandom);
            c_lock = 1'($urandom); c_addr = 7'($urandom); c_wdata = 16'($urandom);
            @(negedge Iclk);
            check("rst_ctl", {h_gnt, c_gnt, m_en, m_we, h_rvalid, c_rvalid, lock_act}, 7'd0);
            check("rst_m_addr", m_addr, 7'd0);
            check("rst_m_wdata", m_wdata, 16'd0);
            check("rst_h_rdata", h_rdata, 16'd0);
            check("rst_c_rdata", c_rdata, 16'd0);
            @(posedge Iclk);
            #1;
        end
        h_req = 1'b0; c_req = 1'b0; c_lock = 1'b0; c_we = 1'b0; h_wrb = 1'b1;
        Ireset = 1'b0;
        idle(2);

        // 2. Host write 5 to address 64, then read it back.
        h_req = 1'b1; h_wrb = 1'b0; h_addr = 7'd64; h_wdata = 16'd5;
        step(1'b1, 1'b0, 7'd64, 1'b1, 16'h0, 1'b0);
        h_wrb = 1'b1;
        step(1'b1, 1'b0, 7'd64, 1'b0, 16'd5, 1'b0);
        h_req = 1'b0;
        idle(3);

        // 3. Both requesting from reset: host, core, host, core; reads pipeline 1/cycle.
        h_req = 1'b1; h_wrb = 1'b1; h_addr = 7'd10;
        c_req = 1'b1; c_we = 1'b0; c_lock = 1'b0; c_addr = 7'd20;
        reset_pulse();
        step(1'b1, 1'b0, 7'd10, 1'b0, 16'hA00A, 1'b0);
        step(1'b0, 1'b1, 7'd20, 1'b0, 16'hA014, 1'b0);
        step(1'b1, 1'b0, 7'd10, 1'b0, 16'hA00A, 1'b0);
        step(1'b0, 1'b1, 7'd20, 1'b0, 16'hA014, 1'b0);
        h_req = 1'b0; c_req = 1'b0;
        idle(3);

        // 4. Two-word core fetch at 0,1 with lock on the first word; host waits one extra cycle.
        h_req = 1'b1; h_addr = 7'd64;
        step(1'b1, 1'b0, 7'd64, 1'b0, 16'd5, 1'b0);
        c_req = 1'b1; c_lock = 1'b1; c_addr = 7'd0;
        step(1'b0, 1'b1, 7'd0, 1'b0, 16'hA000, 1'b0);
        c_lock = 1'b0; c_addr = 7'd1;
        step(1'b0, 1'b1, 7'd1, 1'b0, 16'hA001, 1'b1);
        c_req = 1'b0;
        step(1'b1, 1'b0, 7'd64, 1'b0, 16'd5, 1'b0);
        h_req = 1'b0;
        idle(3);

        // 5. Continuous core lock with host waiting: 4 core grants, then host, then core again.
        h_req = 1'b1; h_addr = 7'd3;
        c_req = 1'b1; c_lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c_addr = 7'(8 + i);
            step(1'b0, 1'b1, 7'(8 + i), 1'b0, 16'hA008 + 16'(i), (i != 0));
        end
        c_addr = 7'd12;
        step(1'b1, 1'b0, 7'd3, 1'b0, 16'hA003, 1'b0);
        step(1'b0, 1'b1, 7'd12, 1'b0, 16'hA00C, 1'b0);
        h_req = 1'b0; c_req = 1'b0;
        step(1'b0, 1'b0, 7'd0, 1'b0, 16'h0, 1'b1);
        idle(3);

        // Core write then read back (address at the top of the map).
        c_req = 1'b1; c_lock = 1'b0; c_we = 1'b1; c_addr = 7'd127; c_wdata = 16'h1234;
        step(1'b0, 1'b1, 7'd127, 1'b1, 16'h0, 1'b0);
        c_we = 1'b0;
        step(1'b0, 1'b1, 7'd127, 1'b0, 16'h1234, 1'b0);
        c_req = 1'b0;
        idle(3);

        // 6. Locked core read granted, reset pulsed in the following cycle.
        c_req = 1'b1; c_lock = 1'b1; c_addr = 7'd5;
        step(1'b0, 1'b1, 7'd5, 1'b0, 16'hA005, 1'b0);
        c_req = 1'b0; c_lock = 1'b0;
        Ireset = 1'b1;
        #3;
        Ireset = 1'b0;
        h_q.delete();
        c_q.delete();
        @(posedge Iclk);
        #1;
        idle(3);
        check("rst_mid_c_rdata", c_rdata, 16'd0);
        check("rst_mid_lock_act", lock_act, 1'b0);
        // After reset the host wins the first tie.
        h_req = 1'b1; h_addr = 7'd64; c_req = 1'b1; c_addr = 7'd2;
        step(1'b1, 1'b0, 7'd64, 1'b0, 16'd5, 1'b0);
        h_req = 1'b0; c_req = 1'b0;
        idle(4);

        check("h_q_drained", h_q.size(), 0);
        check("c_q_drained", c_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
